table_ad_serializer: RTL and testbench

Parametrised successor to the byte-wide table address/data transmitter. It accepts 32-bit table address words (channel select + 24-bit address) and 32-bit data words from the command decoder, buffers them in a small FIFO, and serialises each word onto a SER_WIDTH-bit bus toward the table-write ports of up to NUM_CHANNELS submodules. Unlike its predecessor it accepts back-to-back writes, supports 8/16/32-bit beats, and marks word boundaries explicitly. Out-of-range channels are dropped, and misuse is reported.

---
 rtl/table_ad_serializer.sv | 155 +++++++++++++++
 tb/tb_table_ad_serializer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/table_ad_serializer.sv
// ============================================================================
// Module      : table_ad_serializer
// Description : Buffers 32-bit table address/data words in a small FIFO and
//               serialises them LSB-beat first toward one of NUM_CHANNELS
//               submodule table-write ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module table_ad_serializer #(
    parameter int NUM_CHANNELS = 1,
    parameter int ADDR_BITS    = 4,
    parameter int SER_WIDTH    = 8,
    parameter int FIFO_LOG2    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic                    a_not_d_in,
    input  logic [31:0]             din,
    output logic                    ready,
    output logic [SER_WIDTH-1:0]    ser_d,
    output logic                    ser_first,
    output logic                    a_not_d,
    output logic [NUM_CHANNELS-1:0] chn_en,
    output logic                    err
);

    localparam int                   c_BEATS = 32 / SER_WIDTH;
    localparam int                   c_DEPTH = 1 << FIFO_LOG2;
    localparam logic [1:0]           c_LAST  = 2'(c_BEATS - 1);
    localparam logic [FIFO_LOG2:0]   c_FULL  = (FIFO_LOG2 + 1)'(c_DEPTH);
    localparam logic [ADDR_BITS:0]   c_NCH   = (ADDR_BITS + 1)'(NUM_CHANNELS);
    localparam logic [0:0]           c_IDLE  = 1'b0;
    localparam logic [0:0]           c_SEND  = 1'b1;

    logic [32:0]             r_mem [c_DEPTH];
    logic [FIFO_LOG2-1:0]    r_wr_ptr;
    logic [FIFO_LOG2-1:0]    r_rd_ptr;
    logic [FIFO_LOG2:0]      r_count;
    logic                    r_ready;
    logic [0:0]              r_state;
    logic [1:0]              r_beat;
    logic [31:0]             r_shift;
    logic [ADDR_BITS-1:0]    r_sel;
    logic                    r_sel_valid;
    logic [SER_WIDTH-1:0]    r_ser_d;
    logic                    r_ser_first;
    logic                    r_a_not_d;
    logic [NUM_CHANNELS-1:0] r_chn_en;
    logic                    r_err;

    logic                    w_push;
    logic                    w_last;
    logic                    w_pop;
    logic [32:0]             w_head;
    logic [ADDR_BITS-1:0]    w_head_sel;
    logic [ADDR_BITS-1:0]    w_sel;
    logic                    w_sel_valid;
    logic [NUM_CHANNELS-1:0] w_onehot;
    logic [FIFO_LOG2:0]      w_count_next;

    assign w_push     = we & r_ready;
    assign w_last     = (r_state == c_SEND) && (r_beat == c_LAST);
    assign w_pop      = (r_count != '0) && ((r_state == c_IDLE) || w_last);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_sel = w_head[24 +: ADDR_BITS];

    // An address word selects its own channel; data words reuse the last one.
    assign w_sel       = w_head[32] ? w_head_sel : r_sel;
    assign w_sel_valid = w_head[32] ? ({1'b0, w_head_sel} < c_NCH) : r_sel_valid;
    assign w_onehot    = NUM_CHANNELS'(1) << w_sel;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {a_not_d_in, din};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_ready     <= 1'b1;
            r_state     <= c_IDLE;
            r_beat      <= '0;
            r_shift     <= '0;
            r_sel       <= '0;
            r_sel_valid <= 1'b0;
            r_ser_d     <= '0;
            r_ser_first <= 1'b0;
            r_a_not_d   <= 1'b0;
            r_chn_en    <= '0;
            r_err       <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_ready <= (w_count_next != c_FULL);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (we && !r_ready) begin
                r_err <= 1'b1;
            end

            if (w_pop) begin
                // Loading on the last beat keeps consecutive words gap-free.
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_state     <= c_SEND;
                r_beat      <= '0;
                r_ser_d     <= w_head[SER_WIDTH-1:0];
                r_shift     <= w_head[31:0] >> SER_WIDTH;
                r_ser_first <= 1'b1;
                r_a_not_d   <= w_head[32];
                r_sel       <= w_sel;
                r_sel_valid <= w_sel_valid;
                r_chn_en    <= w_sel_valid ? w_onehot : '0;
                if (!w_sel_valid) begin
                    r_err <= 1'b1;
                end
            end else if (r_state == c_SEND) begin
                if (w_last) begin
                    r_state     <= c_IDLE;
                    r_ser_d     <= '0;
                    r_ser_first <= 1'b0;
                    r_chn_en    <= '0;
                end else begin
                    r_beat      <= r_beat + 2'd1;
                    r_ser_d     <= r_shift[SER_WIDTH-1:0];
                    r_shift     <= r_shift >> SER_WIDTH;
                    r_ser_first <= 1'b0;
                end
            end
        end
    end

    assign ready     = r_ready;
    assign ser_d     = r_ser_d;
    assign ser_first = r_ser_first;
    assign a_not_d   = r_a_not_d;
    assign chn_en    = r_chn_en;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_table_ad_serializer.sv
// ============================================================================
// Module      : tb_table_ad_serializer
// Description : Drives three serializer configurations (8/16/32-bit beats)
//               with shared stimulus and checks them against a word-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_table_ad_serializer;

    logic        clk;
    logic        rst;
    logic        we;
    logic        a_not_d_in;
    logic [31:0] din;

    logic        rdy8,  sf8,  ad8,  er8;
    logic [7:0]  sd8;
    logic [3:0]  ce8;
    logic        rdy16, sf16, ad16, er16;
    logic [15:0] sd16;
    logic [3:0]  ce16;
    logic        rdy32, sf32, ad32, er32;
    logic [31:0] sd32;
    logic [1:0]  ce32;

    int n_pass  = 0;
    int n_total = 0;

    table_ad_serializer #(.NUM_CHANNELS(4), .ADDR_BITS(4), .SER_WIDTH(8), .FIFO_LOG2(2)) u8 (
        .clk(clk), .rst(rst), .we(we), .a_not_d_in(a_not_d_in), .din(din),
        .ready(rdy8), .ser_d(sd8), .ser_first(sf8), .a_not_d(ad8), .chn_en(ce8), .err(er8));

    table_ad_serializer #(.NUM_CHANNELS(4), .ADDR_BITS(4), .SER_WIDTH(16), .FIFO_LOG2(2)) u16 (
        .clk(clk), .rst(rst), .we(we), .a_not_d_in(a_not_d_in), .din(din),
        .ready(rdy16), .ser_d(sd16), .ser_first(sf16), .a_not_d(ad16), .chn_en(ce16), .err(er16));

    table_ad_serializer #(.NUM_CHANNELS(2), .ADDR_BITS(4), .SER_WIDTH(32), .FIFO_LOG2(2)) u32 (
        .clk(clk), .rst(rst), .we(we), .a_not_d_in(a_not_d_in), .din(din),
        .ready(rdy32), .ser_d(sd32), .ser_first(sf32), .a_not_d(ad32), .chn_en(ce32), .err(er32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- word-level model, one slot per configuration ----------------
    function automatic int beats_of(input int k);
        return (k == 0) ? 4 : (k == 1) ? 2 : 1;
    endfunction
    function automatic int width_of(input int k);
        return (k == 0) ? 8 : (k == 1) ? 16 : 32;
    endfunction
    function automatic int nch_of(input int k);
        return (k == 2) ? 2 : 4;
    endfunction

    logic [32:0] m_mem [3][4];
    int          m_cnt [3];
    bit          m_ready [3];
    bit          m_send [3];
    bit          m_anot [3];
    bit          m_selv [3];
    bit          m_err [3];
    logic [31:0] m_word [3];
    int          m_beat [3];
    int          m_sel [3];
    logic [3:0]  m_chn [3];

    task automatic model_reset(input int k);
        m_cnt[k] = 0; m_ready[k] = 1; m_send[k] = 0; m_anot[k] = 0;
        m_selv[k] = 0; m_err[k] = 0; m_word[k] = 0; m_beat[k] = 0;
        m_sel[k] = 0; m_chn[k] = 0;
    endtask

    task automatic model_step(input int k);
        logic [32:0] e;
        bit push, pop;
        push = we && m_ready[k];
        pop  = (m_cnt[k] > 0) && (!m_send[k] || m_beat[k] == beats_of(k) - 1);
        if (we && !m_ready[k]) m_err[k] = 1;
        if (pop) begin
            e = m_mem[k][0];
            for (int i = 0; i < 3; i++) m_mem[k][i] = m_mem[k][i+1];
            m_cnt[k]--;
            m_send[k] = 1;
            m_beat[k] = 0;
            m_word[k] = e[31:0];
            m_anot[k] = e[32];
            if (e[32]) begin
                m_sel[k]  = int'(e[27:24]);
                m_selv[k] = (m_sel[k] < nch_of(k));
            end
            if (!m_selv[k]) m_err[k] = 1;
            m_chn[k] = m_selv[k] ? 4'(1 << m_sel[k]) : 4'b0;
        end else if (m_send[k]) begin
            if (m_beat[k] == beats_of(k) - 1) m_send[k] = 0;
            else m_beat[k]++;
        end
        if (push) begin
            m_mem[k][m_cnt[k]] = {a_not_d_in, din};
            m_cnt[k]++;
        end
        m_ready[k] = (m_cnt[k] != 4);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) model_reset(k);
        end else begin
            for (int k = 0; k < 3; k++) model_step(k);
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                logic [31:0] a_sd, e_sd, mask;
                logic [3:0]  a_ce;
                logic        a_sf, a_ad, a_rd, a_er;
                case (k)
                    0:       begin a_sd = 32'(sd8);  a_ce = ce8;          a_sf = sf8;  a_ad = ad8;  a_rd = rdy8;  a_er = er8;  end
                    1:       begin a_sd = 32'(sd16); a_ce = ce16;         a_sf = sf16; a_ad = ad16; a_rd = rdy16; a_er = er16; end
                    default: begin a_sd = sd32;      a_ce = {2'b00, ce32}; a_sf = sf32; a_ad = ad32; a_rd = rdy32; a_er = er32; end
                endcase
                mask = (width_of(k) == 32) ? 32'hFFFF_FFFF : ((32'h1 << width_of(k)) - 32'h1);
                e_sd = m_send[k] ? ((m_word[k] >> (m_beat[k] * width_of(k))) & mask) : 32'h0;
                chk($sformatf("model_ser_d[%0d]", k),     a_sd, e_sd);
                chk($sformatf("model_ser_first[%0d]", k), 32'(a_sf), 32'(m_send[k] && m_beat[k] == 0));
                chk($sformatf("model_a_not_d[%0d]", k),   32'(a_ad), 32'(m_anot[k]));
                chk($sformatf("model_chn_en[%0d]", k),    32'(a_ce), m_send[k] ? 32'(m_chn[k]) : 32'h0);
                chk($sformatf("model_ready[%0d]", k),     32'(a_rd), 32'(m_ready[k]));
                chk($sformatf("model_err[%0d]", k),       32'(a_er), 32'(m_err[k]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic nx();
        @(negedge clk);
    endtask

    task automatic wr(input logic a, input logic [31:0] d);
        we = 1'b1; a_not_d_in = a; din = d;
    endtask

    task automatic idle();
        we = 1'b0; a_not_d_in = 1'b0; din = 32'h0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        nx();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) nx();
        chk("reset_ready8", 32'(rdy8), 32'h1);
        chk("reset_err8", 32'(er8), 32'h0);
        chk("reset_ser_d8", 32'(sd8), 32'h0);

        // 8-bit beats: address then data, no gap between words
        do_reset();
        wr(1'b1, 32'h0200_0010);
        nx(); idle();
        nx(); wr(1'b0, 32'hAABB_CCDD);
        chk("t1_a0_ser_d", 32'(sd8), 32'h10);
        chk("t1_a0_first", 32'(sf8), 32'h1);
        chk("t1_a0_anot", 32'(ad8), 32'h1);
        chk("t1_a0_chn", 32'(ce8), 32'h4);
        nx(); idle();
        chk("t1_a1_ser_d", 32'(sd8), 32'h00);
        chk("t1_a1_first", 32'(sf8), 32'h0);
        nx(); chk("t1_a2_ser_d", 32'(sd8), 32'h00);
        nx(); chk("t1_a3_ser_d", 32'(sd8), 32'h02);
        nx();
        chk("t1_d0_ser_d", 32'(sd8), 32'hDD);
        chk("t1_d0_first", 32'(sf8), 32'h1);
        chk("t1_d0_anot", 32'(ad8), 32'h0);
        chk("t1_d0_chn", 32'(ce8), 32'h4);
        nx(); chk("t1_d1_ser_d", 32'(sd8), 32'hCC);
        nx(); chk("t1_d2_ser_d", 32'(sd8), 32'hBB);
        nx(); chk("t1_d3_ser_d", 32'(sd8), 32'hAA);
        chk("t1_d3_chn", 32'(ce8), 32'h4);
        nx();
        chk("t1_idle_ser_d", 32'(sd8), 32'h0);
        chk("t1_idle_first", 32'(sf8), 32'h0);
        chk("t1_idle_chn", 32'(ce8), 32'h0);
        chk("t1_idle_anot", 32'(ad8), 32'h0);
        repeat (4) nx();

        // 16-bit beats: burst overflows the FIFO
        do_reset();
        wr(1'b1, 32'h0100_0000);
        for (int i = 1; i <= 7; i++) begin
            nx();
            if (i == 6) begin
                chk("t2_ready_before_full", 32'(rdy16), 32'h1);
                chk("t2_err_before_full", 32'(er16), 32'h0);
            end
            if (i == 7) chk("t2_ready_full", 32'(rdy16), 32'h0);
            wr(1'b0, 32'h1000 + 32'(i));
        end
        nx(); idle();
        chk("t2_err_after_reject", 32'(er16), 32'h1);
        chk("t2_ready_after_pop", 32'(rdy16), 32'h1);
        repeat (40) nx();

        // 32-bit beats: one word per cycle
        do_reset();
        wr(1'b1, 32'h0100_0123);
        nx(); wr(1'b0, 32'h1111_1111);
        nx(); wr(1'b0, 32'h2222_2222);
        chk("t3_w0_ser_d", sd32, 32'h0100_0123);
        chk("t3_w0_first", 32'(sf32), 32'h1);
        chk("t3_w0_chn", 32'(ce32), 32'h2);
        nx(); idle();
        chk("t3_w1_ser_d", sd32, 32'h1111_1111);
        chk("t3_w1_first", 32'(sf32), 32'h1);
        nx();
        chk("t3_w2_ser_d", sd32, 32'h2222_2222);
        chk("t3_w2_first", 32'(sf32), 32'h1);
        nx();
        chk("t3_idle_first", 32'(sf32), 32'h0);
        chk("t3_err", 32'(er32), 32'h0);
        repeat (10) nx();

        // out-of-range channel, then recovery
        do_reset();
        wr(1'b1, 32'h0500_0000);
        nx(); wr(1'b0, 32'h1234_5678);
        nx(); idle();
        chk("t4_oor_addr_chn", 32'(ce32), 32'h0);
        chk("t4_oor_addr_anot", 32'(ad32), 32'h1);
        chk("t4_oor_err", 32'(er32), 32'h1);
        nx();
        chk("t4_oor_data_chn", 32'(ce32), 32'h0);
        chk("t4_oor_data_ser_d", sd32, 32'h1234_5678);
        nx(); wr(1'b1, 32'h0100_0000);
        nx(); idle();
        nx();
        chk("t4_recover_chn", 32'(ce32), 32'h2);
        chk("t4_recover_first", 32'(sf32), 32'h1);
        repeat (12) nx();

        // data word with no address since reset
        do_reset();
        wr(1'b0, 32'hCAFE_F00D);
        nx(); idle();
        nx();
        chk("t5_ser_d", 32'(sd8), 32'h0D);
        chk("t5_first", 32'(sf8), 32'h1);
        chk("t5_chn", 32'(ce8), 32'h0);
        chk("t5_err", 32'(er8), 32'h1);
        repeat (8) nx();

        // asynchronous reset during beat 2 with two words queued
        do_reset();
        wr(1'b1, 32'h0300_0000);
        nx(); wr(1'b0, 32'h0A0B_0C0D);
        nx(); wr(1'b0, 32'h0102_0304);
        nx(); idle();
        nx();
        chk("t6_beat2_chn", 32'(ce8), 32'h8);
        chk("t6_beat2_first", 32'(sf8), 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_ser_d", 32'(sd8), 32'h0);
        chk("t6_rst_chn", 32'(ce8), 32'h0);
        chk("t6_rst_anot", 32'(ad8), 32'h0);
        chk("t6_rst_ready", 32'(rdy8), 32'h1);
        chk("t6_rst_err", 32'(er8), 32'h0);
        nx(); rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            nx();
            chk("t6_post_first", 32'(sf8), 32'h0);
            chk("t6_post_chn", 32'(ce8), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
